// File: rtl/apb_cfg_master_pkg.sv
// Shared types and constants for the APB configuration initiator.
// Imported by apb_cfg_master and its bench.
package apb_cfg_master_pkg;

  localparam int APB_DW = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

endpackage

// File: rtl/apb_cfg_master.sv
// APB initiator: one request becomes one SETUP/ACCESS transfer,
// with a bounded PREADY wait and a valid/ready response channel.
module apb_cfg_master
  import apb_cfg_master_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic [APB_ADDR_WIDTH-1:0] req_addr_i,
  input  logic [APB_DW-1:0]         req_wdata_i,
  input  logic                      req_write_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [APB_DW-1:0]         rsp_rdata_o,
  output logic                      rsp_err_o,
  output logic                      rsp_timeout_o,
  output logic [APB_ADDR_WIDTH-1:0] PADDR,
  output logic [APB_DW-1:0]         PWDATA,
  output logic                      PWRITE,
  output logic                      PSEL,
  output logic                      PENABLE,
  input  logic [APB_DW-1:0]         PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR
);

  // Width 1 keeps the counter legal when the timeout is disabled.
  localparam int CW =
    (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TO_LAST =
    (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [APB_ADDR_WIDTH-1:0] ALIGN_MASK =
    ~APB_ADDR_WIDTH'(3);

  state_e        state;
  logic [CW-1:0] wait_cnt;

  assign req_ready_o = (state == IDLE);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state         <= IDLE;
      wait_cnt      <= '0;
      PADDR         <= '0;
      PWDATA        <= '0;
      PWRITE        <= 1'b0;
      PSEL          <= 1'b0;
      PENABLE       <= 1'b0;
      rsp_valid_o   <= 1'b0;
      rsp_rdata_o   <= '0;
      rsp_err_o     <= 1'b0;
      rsp_timeout_o <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid_i) begin
            PADDR   <= req_addr_i & ALIGN_MASK;
            PWDATA  <= req_wdata_i;
            PWRITE  <= req_write_i;
            PSEL    <= 1'b1;
            PENABLE <= 1'b0;
            state   <= SETUP;
          end
        end
        SETUP: begin
          PENABLE  <= 1'b1;
          wait_cnt <= '0;
          state    <= ACCESS;
        end
        ACCESS: begin
          // PREADY has priority over a timeout firing this cycle.
          if (PREADY) begin
            PSEL          <= 1'b0;
            PENABLE       <= 1'b0;
            rsp_rdata_o   <= PWRITE ? '0 : PRDATA;
            rsp_err_o     <= PSLVERR;
            rsp_timeout_o <= 1'b0;
            rsp_valid_o   <= 1'b1;
            state         <= RESP;
          end else if (TIMEOUT_CYCLES != 0 &&
                       wait_cnt == TO_LAST) begin
            PSEL          <= 1'b0;
            PENABLE       <= 1'b0;
            rsp_rdata_o   <= '0;
            rsp_err_o     <= 1'b1;
            rsp_timeout_o <= 1'b1;
            rsp_valid_o   <= 1'b1;
            state         <= RESP;
          end else if (wait_cnt != CNT_MAX) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/apb_cfg_master.md
Name: apb_cfg_master

Overview:
- APB initiator that turns a simple valid/ready register-access request into a single APB transfer (SETUP, then ACCESS).
- Returns read data and error status on a valid/ready response channel.
- Used by config/boot controllers to program peripheral register slaves (clock dividers, pad control) over the peripheral APB bus.
- Adds a bounded PREADY wait (timeout) so a hung slave cannot stall the initiator forever.

Parameters:
- APB_ADDR_WIDTH, 12: width of request address and PADDR.
- TIMEOUT_CYCLES, 256: maximum ACCESS cycles waiting for PREADY; 0 disables the timeout.

Ports:
- HCLK  in  1  clock
- HRESETn  in  1  reset, asynchronous, active-low
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when high together with req_valid_i
- req_addr_i  in  APB_ADDR_WIDTH  register byte address
- req_wdata_i  in  32  write data
- req_write_i  in  1  1 = write, 0 = read
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response consumed
- rsp_rdata_o  out  32  read data (0 for writes and for timeouts)
- rsp_err_o  out  1  PSLVERR seen, or timeout
- rsp_timeout_o  out  1  transfer aborted by timeout
- PADDR  out  APB_ADDR_WIDTH  APB address
- PWDATA  out  32  APB write data
- PWRITE  out  1  APB direction
- PSEL  out  1  APB select
- PENABLE  out  1  APB enable
- PRDATA  in  32  APB read data
- PREADY  in  1  APB ready
- PSLVERR  in  1  APB slave error

Behaviour:
- One clock, HCLK. Reset is asynchronous and active-low on HRESETn. All outputs are registered except req_ready_o, which is decoded from state.
- Reset values:
  - All APB outputs: 0.
  - rsp_valid_o, rsp_err_o, rsp_timeout_o: 0. rsp_rdata_o: 0.
  - FSM in IDLE, wait counter 0.
- IDLE:
  - req_ready_o = 1 (asserted only in this state).
  - On req_valid_i && req_ready_o:
    - PADDR <= {req_addr_i[AW-1:2], 2'b00} (word-aligned; low two bits forced to 0).
    - PWDATA <= req_wdata_i, PWRITE <= req_write_i.
    - PSEL <= 1, PENABLE <= 0.
    - Go to SETUP.
- SETUP:
  - Lasts exactly one cycle.
  - PENABLE <= 1, wait counter <= 0, go to ACCESS.
  - PREADY is ignored in SETUP.
- ACCESS:
  - PADDR, PWDATA, PWRITE, PSEL and PENABLE are held stable.
  - PREADY == 1:
    - PSEL <= 0, PENABLE <= 0.
    - rsp_rdata_o <= PWRITE ? 0 : PRDATA.
    - rsp_err_o <= PSLVERR, rsp_timeout_o <= 0.
    - rsp_valid_o <= 1, go to RESP.
  - PREADY == 0 and TIMEOUT_CYCLES != 0 and counter == TIMEOUT_CYCLES-1:
    - Abort: PSEL <= 0, PENABLE <= 0.
    - rsp_rdata_o <= 0, rsp_err_o <= 1, rsp_timeout_o <= 1.
    - rsp_valid_o <= 1, go to RESP.
  - Otherwise: counter increments. Counter width is $clog2(TIMEOUT_CYCLES+1) and it saturates, never wraps.
  - PREADY rising in the same cycle the timeout would fire: PREADY wins, so the transfer completes normally.
- RESP:
  - rsp_* outputs are held stable while rsp_valid_o && !rsp_ready_i.
  - On rsp_ready_i: rsp_valid_o <= 0, go to IDLE.
  - No new request is accepted until the following cycle in IDLE. Minimum spacing is 4 cycles per transfer.
- Latency, with the request accepted at cycle 0 and zero-wait-state PREADY:
  - PSEL = 1 at cycle 1.
  - PENABLE = 1 at cycle 2.
  - rsp_valid_o = 1 at cycle 3.
  - Each PREADY wait cycle adds 1.
- PADDR, PWDATA and PWRITE keep their last values after a transfer; they only change on acceptance.
- Reset mid-transfer: PSEL and PENABLE drop immediately (asynchronously), any pending response is discarded, FSM returns to IDLE.
- PSLVERR is sampled only when PREADY == 1 in ACCESS.

Decomposition:
- Package apb_cfg_master_pkg holds:
  - state enum typedef: IDLE, SETUP, ACCESS, RESP (2-bit encoding).
  - APB data-width constant, 32.
- Single module; the wait counter is inline. No sub-module is warranted.

Test Plan:
- Write, zero wait: req addr 0x008, wdata 0x0000000A, write=1; PREADY tied 1 -> PSEL at cycle 1, PENABLE at cycle 2, PADDR=0x008, PWDATA=0x0A; rsp_valid at cycle 3 with err=0, rdata=0.
- Read with waits: addr 0x004; PREADY low for 3 ACCESS cycles, then high with PRDATA=0x00000005 -> rsp_valid at cycle 6, rsp_rdata=0x05, err=0; PSEL and PENABLE stable for all 4 ACCESS cycles.
- Slave error: write to 0x00C; PREADY=1, PSLVERR=1 -> rsp_err=1, rsp_timeout=0; PSEL low in the response cycle.
- Timeout: TIMEOUT_CYCLES=8, PREADY stuck 0 -> PSEL drops after 8 ACCESS cycles, rsp_err=1, rsp_timeout=1, rdata=0. Also: PREADY=1 on the 8th ACCESS cycle -> normal completion, rsp_timeout=0.
- Backpressure and misalignment: rsp_ready_i low for 5 cycles -> rsp_* stable, req_ready_o=0, no PSEL activity; next request addr 0x007 drives PADDR=0x004.
- Reset mid-ACCESS: assert HRESETn=0 while PENABLE=1 -> PSEL, PENABLE, rsp_valid_o low immediately; after release req_ready_o=1 and no response is emitted.
